// File: rtl/aileron_rampa.sv
// ---------------------------------------------------------------------------
// aileron_rampa
// Slew-rate limiter for the aileron valve decoder. A pilot target angle is
// latched and the registered output angle walks toward it one unit at a time,
// one step every PASSO_CICLOS clocks. The decoder downstream never sees a
// jump larger than one unit, and a sign change always passes through zero.
//
// Parameters:
//   PASSO_CICLOS  clocks per one-unit step of angulo (>= 1)
//   ANG_MAX       saturation magnitude for the target and angulo
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   alvo     in   [3:0] requested target angle, signed
//   carrega  in   load strobe, samples alvo on the clock edge
//   centrar  in   emergency centering, forces target to 0, beats carrega
//   angulo   out  [3:0] current commanded angle, signed, registered
//   estavel  out  angulo has reached the latched target, no ramp running
//   ocupado  out  registered inverse of estavel
// ---------------------------------------------------------------------------
module aileron_rampa #(
    parameter int PASSO_CICLOS = 4,
    parameter int ANG_MAX      = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [3:0]  alvo,
    input  logic               carrega,
    input  logic               centrar,
    output logic signed [3:0]  angulo,
    output logic               estavel,
    output logic               ocupado
);

    // The step counter needs at least one bit even when a step happens on
    // every clock (PASSO_CICLOS = 1); in that case it simply stays at zero.
    localparam int CW = (PASSO_CICLOS > 1) ? $clog2(PASSO_CICLOS) : 1;
    localparam logic [CW-1:0]     ULTIMO = CW'(PASSO_CICLOS - 1);
    localparam logic signed [3:0] MAXV   = 4'(ANG_MAX);
    localparam logic signed [3:0] MINV   = -MAXV;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBINDO  = 2'd1,
        DESCENDO = 2'd2
    } estado_t;

    estado_t            estado, estadoNext;
    logic signed [3:0]  alvoReg, alvoNext;
    logic signed [3:0]  alvoClamp;
    logic signed [3:0]  anguloNext;
    logic signed [3:0]  anguloPasso;
    logic [CW-1:0]      contador, contadorNext;
    logic               estavelNext;

    // Direction of travel from a given angle toward a given target, using
    // signed comparison so that negative targets are handled correctly.
    function automatic estado_t direcao(input logic signed [3:0] t,
                                        input logic signed [3:0] a);
        if (t > a)
            return SUBINDO;
        else if (t < a)
            return DESCENDO;
        else
            return PARADO;
    endfunction

    // Saturate the incoming request to -ANG_MAX..+ANG_MAX. This also turns
    // the asymmetric two's complement value -8 into -ANG_MAX, so the ramp
    // is always symmetric around zero.
    always_comb begin
        alvoClamp = alvo;
        if (alvo > MAXV)
            alvoClamp = MAXV;
        else if (alvo < MINV)
            alvoClamp = MINV;
    end

    // Candidate angle if a step is taken this cycle: one unit toward the
    // target in the current direction of travel. Because the target is
    // always inside the legal range and we stop on arrival, this can never
    // leave the range or wrap.
    always_comb begin
        anguloPasso = angulo;
        if (estado == SUBINDO)
            anguloPasso = angulo + 4'sd1;
        else if (estado == DESCENDO)
            anguloPasso = angulo - 4'sd1;
    end

    // Next-state logic. A target update (centering or load) takes priority
    // over stepping: it restarts the step timing and re-evaluates direction
    // against the present angle without moving it, so a step that would have
    // landed on the same edge is dropped. Otherwise, while ramping, the
    // counter runs and every PASSO_CICLOS clocks the angle moves one unit;
    // the direction after the step is checked against the new angle so the
    // ramp stops exactly on the target. The settled flag is derived from the
    // next state so it changes on the same edge as the state itself.
    always_comb begin
        alvoNext     = alvoReg;
        anguloNext   = angulo;
        contadorNext = contador;
        estadoNext   = estado;

        if (centrar)
            alvoNext = 4'sd0;
        else if (carrega)
            alvoNext = alvoClamp;

        if (centrar || carrega) begin
            contadorNext = '0;
            estadoNext   = direcao(alvoNext, angulo);
        end else begin
            case (estado)
                SUBINDO, DESCENDO: begin
                    if (contador == ULTIMO) begin
                        anguloNext   = anguloPasso;
                        contadorNext = '0;
                        estadoNext   = direcao(alvoReg, anguloPasso);
                    end else begin
                        contadorNext = contador + CW'(1);
                    end
                end
                default: begin
                    contadorNext = '0;
                    estadoNext   = PARADO;
                end
            endcase
        end

        estavelNext = (estadoNext == PARADO);
    end

    // State register. Reset is asynchronous so a ramp in progress is
    // abandoned immediately: the angle snaps to centre and no pending step
    // can fire afterwards because the counter and state are cleared too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= PARADO;
            alvoReg  <= 4'sd0;
            angulo   <= 4'sd0;
            contador <= '0;
            estavel  <= 1'b1;
            ocupado  <= 1'b0;
        end else begin
            estado   <= estadoNext;
            alvoReg  <= alvoNext;
            angulo   <= anguloNext;
            contador <= contadorNext;
            estavel  <= estavelNext;
            ocupado  <= ~estavelNext;
        end
    end

endmodule
